// File: rtl/stream_row_router_if.sv
// Handshake bundle between the address generator / scratchpad / PE row and stream_row_router.
// master drives the inputs (testbench or upstream logic); slave is the router itself.
interface stream_row_router_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int SPAD_N          = 8,
    parameter int WORD_ADDR_WIDTH = 8,
    parameter int ADDR_WIDTH      = WORD_ADDR_WIDTH + $clog2(SPAD_N),
    parameter int ADDR_LENGTH     = 9
) ();
    logic [ADDR_LENGTH*ADDR_WIDTH-1:0] i_ag_addr;
    logic                              i_ag_valid;
    logic                              o_ag_ready;
    logic [SPAD_N*DATA_WIDTH-1:0]      i_spad_data;
    logic [WORD_ADDR_WIDTH-1:0]        i_spad_addr;
    logic                              i_spad_valid;
    logic                              o_spad_ready;
    logic [DATA_WIDTH-1:0]             o_data;
    logic                              o_valid;
    logic                              i_ready;
    logic                              o_aq_empty;
    logic [15:0]                       o_elem_count;

    modport master (
        output i_ag_addr, i_ag_valid, i_spad_data, i_spad_addr, i_spad_valid, i_ready,
        input  o_ag_ready, o_spad_ready, o_data, o_valid, o_aq_empty, o_elem_count
    );

    modport slave (
        input  i_ag_addr, i_ag_valid, i_spad_data, i_spad_addr, i_spad_valid, i_ready,
        output o_ag_ready, o_spad_ready, o_data, o_valid, o_aq_empty, o_elem_count
    );
endinterface

// File: rtl/stream_row_router.sv
// Input row router: queues element addresses, matches up to PEEK_W head entries per scratchpad word,
// and drains matched elements to the PE row. Define STREAM_ROW_ROUTER_PAD_EN for all-ones zero-pad entries.
module stream_row_router #(
    parameter int DATA_WIDTH      = 8,
    parameter int SPAD_N          = 8,
    parameter int WORD_ADDR_WIDTH = 8,
    parameter int ADDR_WIDTH      = WORD_ADDR_WIDTH + $clog2(SPAD_N),
    parameter int ADDR_LENGTH     = 9,
    parameter int AQ_DEPTH        = 16,
    parameter int OQ_DEPTH        = 16,
    parameter int PEEK_W          = 4
) (
    input logic                i_clk,
    input logic                i_rst,
    input logic                i_clear,
    stream_row_router_if.slave bus
);
    localparam int LANE_W = $clog2(SPAD_N);
    localparam int AQ_PW  = $clog2(AQ_DEPTH);
    localparam int AQ_CW  = AQ_PW + 1;
    localparam int OQ_PW  = $clog2(OQ_DEPTH);
    localparam int OQ_CW  = OQ_PW + 1;
    localparam int N_W    = $clog2(PEEK_W + 1);

    logic [ADDR_WIDTH-1:0] aq_mem [AQ_DEPTH];
    logic [AQ_PW-1:0]      aq_wr;
    logic [AQ_PW-1:0]      aq_rd;
    logic [AQ_CW-1:0]      aq_cnt;

    logic [DATA_WIDTH-1:0] oq_mem [OQ_DEPTH];
    logic [OQ_PW-1:0]      oq_wr;
    logic [OQ_PW-1:0]      oq_rd;
    logic [OQ_CW-1:0]      oq_cnt;

    logic [15:0]           elem_count;

    logic                  ag_ready;
    logic                  spad_ready;
    logic                  ag_wr;
    logic                  accept;
    logic                  oq_pop;
    logic [N_W-1:0]        run_n;
    logic [DATA_WIDTH-1:0] push_elem [PEEK_W];

    function automatic logic [DATA_WIDTH-1:0] lane_select(
        input logic [SPAD_N*DATA_WIDTH-1:0] word,
        input logic [LANE_W-1:0]            lane
    );
        return word[int'(lane)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Readiness uses registered counts only: a pop this cycle does not free space until next cycle.
    assign ag_ready   = (AQ_CW'(AQ_DEPTH) - aq_cnt) >= AQ_CW'(ADDR_LENGTH);
    assign spad_ready = (OQ_CW'(OQ_DEPTH) - oq_cnt) >= OQ_CW'(PEEK_W);
    assign ag_wr      = bus.i_ag_valid & ag_ready;
    assign accept     = bus.i_spad_valid & spad_ready;
    assign oq_pop     = (oq_cnt != '0) & bus.i_ready;

    always_comb begin
        logic [ADDR_WIDTH-1:0] head_addr;
        logic                  qual;
        logic                  run_on;
        run_n     = '0;
        run_on    = 1'b1;
        head_addr = '0;
        qual      = 1'b0;
        for (int k = 0; k < PEEK_W; k++) begin
            push_elem[k] = '0;
        end
        for (int k = 0; k < PEEK_W; k++) begin
            head_addr    = aq_mem[aq_rd + AQ_PW'(k)];
            qual         = (k < int'(aq_cnt)) && accept &&
                           (head_addr[ADDR_WIDTH-1:LANE_W] == bus.i_spad_addr);
            push_elem[k] = lane_select(bus.i_spad_data, head_addr[LANE_W-1:0]);
`ifdef STREAM_ROW_ROUTER_PAD_EN
            // Pad entries need no scratchpad word, only room in the output queue.
            if ((k < int'(aq_cnt)) && (&head_addr) && spad_ready) begin
                qual         = 1'b1;
                push_elem[k] = '0;
            end
`endif
            if (run_on && qual) begin
                run_n = run_n + N_W'(1);
            end else begin
                run_on = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            aq_wr      <= '0;
            aq_rd      <= '0;
            aq_cnt     <= '0;
            oq_wr      <= '0;
            oq_rd      <= '0;
            oq_cnt     <= '0;
            elem_count <= '0;
        end else begin
            if (ag_wr) begin
                aq_wr <= aq_wr + AQ_PW'(ADDR_LENGTH);
            end
            aq_rd  <= aq_rd + AQ_PW'(run_n);
            aq_cnt <= aq_cnt + (ag_wr ? AQ_CW'(ADDR_LENGTH) : AQ_CW'(0)) - AQ_CW'(run_n);
            oq_wr  <= oq_wr + OQ_PW'(run_n);
            if (oq_pop) begin
                oq_rd      <= oq_rd + OQ_PW'(1);
                elem_count <= elem_count + 16'd1;
            end
            oq_cnt <= oq_cnt + OQ_CW'(run_n) - OQ_CW'(oq_pop);
        end
    end

    // Queue storage is data only; validity is carried entirely by the pointers and counts.
    always_ff @(posedge i_clk) begin
        if (ag_wr && !i_rst && !i_clear) begin
            for (int j = 0; j < ADDR_LENGTH; j++) begin
                aq_mem[aq_wr + AQ_PW'(j)] <= bus.i_ag_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        for (int k = 0; k < PEEK_W; k++) begin
            if (N_W'(k) < run_n) begin
                oq_mem[oq_wr + OQ_PW'(k)] <= push_elem[k];
            end
        end
    end

    assign bus.o_ag_ready   = ag_ready;
    assign bus.o_spad_ready = spad_ready;
    assign bus.o_valid      = (oq_cnt != '0);
    assign bus.o_data       = (oq_cnt != '0) ? oq_mem[oq_rd] : '0;
    assign bus.o_aq_empty   = (aq_cnt == '0);
    assign bus.o_elem_count = elem_count;
endmodule

// File: tb/tb_stream_row_router.sv
// Scoreboard bench for stream_row_router: directed stimulus pushes expected elements,
// a negedge monitor pops and compares every element the router hands out.
`timescale 1ns/1ps
module tb_stream_row_router;
    localparam int DATA_WIDTH      = 8;
    localparam int SPAD_N          = 8;
    localparam int WORD_ADDR_WIDTH = 8;
    localparam int ADDR_WIDTH      = 11;
    localparam int ADDR_LENGTH     = 9;
    localparam int TMO             = 200;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clear = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_WIDTH-1:0] exp_q [$];
    logic [ADDR_WIDTH-1:0] av [ADDR_LENGTH];

    stream_row_router_if bus ();

    stream_row_router dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clear(clear),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait exceeded %0d cycles", name, TMO);
    endtask

    function automatic logic [SPAD_N*DATA_WIDTH-1:0] make_word(input logic [7:0] base);
        logic [SPAD_N*DATA_WIDTH-1:0] w;
        for (int i = 0; i < SPAD_N; i++) w[i*DATA_WIDTH +: DATA_WIDTH] = base + 8'(i);
        return w;
    endfunction

    task automatic fill_seq(input logic [ADDR_WIDTH-1:0] start);
        for (int i = 0; i < ADDR_LENGTH; i++) av[i] = start + ADDR_WIDTH'(i);
    endtask

    task automatic expect_seq(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 8'(i));
    endtask

    task automatic load_av();
        for (int i = 0; i < ADDR_LENGTH; i++) bus.i_ag_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = av[i];
    endtask

    task automatic ag_send();
        int cyc = 0;
        load_av();
        bus.i_ag_valid = 1'b1;
        while (!bus.o_ag_ready && cyc < TMO) begin
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= TMO) timeout("ag_ready");
        @(posedge clk); #1;
        bus.i_ag_valid = 1'b0;
    endtask

    task automatic spad_send(input logic [7:0] waddr, input logic [SPAD_N*DATA_WIDTH-1:0] word);
        int cyc = 0;
        bus.i_spad_addr  = waddr;
        bus.i_spad_data  = word;
        bus.i_spad_valid = 1'b1;
        while (!bus.o_spad_ready && cyc < TMO) begin
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= TMO) timeout("spad_ready");
        @(posedge clk); #1;
        bus.i_spad_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || bus.o_valid) && cyc < TMO) begin
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= TMO) timeout("drain");
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " o_valid"},      32'(bus.o_valid), 0);
        check({tag, " o_data"},       32'(bus.o_data), 0);
        check({tag, " o_aq_empty"},   32'(bus.o_aq_empty), 1);
        check({tag, " o_ag_ready"},   32'(bus.o_ag_ready), 1);
        check({tag, " o_spad_ready"}, 32'(bus.o_spad_ready), 1);
        check({tag, " o_elem_count"}, 32'(bus.o_elem_count), 0);
    endtask

    // Monitor: every accepted output element must be the next expected one.
    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL o_data unexpected: got 0x%0h, required no element", bus.o_data);
            end else begin
                check("o_data", 32'(bus.o_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bus.i_ag_addr    = '0;
        bus.i_ag_valid   = 1'b0;
        bus.i_spad_data  = '0;
        bus.i_spad_addr  = '0;
        bus.i_spad_valid = 1'b0;
        bus.i_ready      = 1'b1;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Contiguous multi-pop: 4, 4, 1
        fill_seq(11'h000);
        ag_send();
        check("contig aq_empty after write", 32'(bus.o_aq_empty), 0);
        expect_seq(8'h10, 4); spad_send(8'd0, make_word(8'h10));
        expect_seq(8'h14, 4); spad_send(8'd0, make_word(8'h10));
        expect_seq(8'h20, 1); spad_send(8'd1, make_word(8'h20));
        wait_drain();
        check("contig elem_count", 32'(bus.o_elem_count), 9);
        check("contig aq_empty", 32'(bus.o_aq_empty), 1);

        // Sparse match: one element per word
        fill_seq(11'h02E);
        av[0] = 11'h005;
        av[1] = 11'h009;
        ag_send();
        exp_q.push_back(8'h45); spad_send(8'd0, make_word(8'h40));
        exp_q.push_back(8'h51); spad_send(8'd1, make_word(8'h50));
        wait_drain();
        check("sparse elem_count", 32'(bus.o_elem_count), 11);
        check("sparse aq_empty", 32'(bus.o_aq_empty), 0);

        // Clear mid-stream with a full address queue and queued output
        bus.i_ready = 1'b0;
        fill_seq(11'h060);
        ag_send();
        check("full ag_ready", 32'(bus.o_ag_ready), 0);
        spad_send(8'd6, make_word(8'h30));
        check("pre-clear o_valid", 32'(bus.o_valid), 1);
        load_av();
        bus.i_ag_valid   = 1'b1;
        bus.i_spad_addr  = 8'd6;
        bus.i_spad_data  = make_word(8'h30);
        bus.i_spad_valid = 1'b1;
        clear            = 1'b1;
        @(posedge clk); #1;
        clear            = 1'b0;
        bus.i_ag_valid   = 1'b0;
        bus.i_spad_valid = 1'b0;
        check_reset_state("clear");
        bus.i_ready = 1'b1;
        fill_seq(11'h070);
        ag_send();
        spad_send(8'd12, make_word(8'h90));
        repeat (3) @(posedge clk);
        #1;
        check("stale word no output", 32'(bus.o_valid), 0);
        check("post-clear aq_empty", 32'(bus.o_aq_empty), 0);
        expect_seq(8'h60, 4); spad_send(8'd14, make_word(8'h60));
        expect_seq(8'h64, 4); spad_send(8'd14, make_word(8'h60));
        expect_seq(8'h70, 1); spad_send(8'd15, make_word(8'h70));
        wait_drain();
        check("post-clear elem_count", 32'(bus.o_elem_count), 9);

        // Backpressure on both sides
        bus.i_ready = 1'b0;
        fill_seq(11'h000);
        ag_send();
        check("aq free 7 ag_ready", 32'(bus.o_ag_ready), 0);
        expect_seq(8'h80, 4); spad_send(8'd0, make_word(8'h80));
        expect_seq(8'h84, 4); spad_send(8'd0, make_word(8'h80));
        expect_seq(8'h90, 1); spad_send(8'd1, make_word(8'h90));
        check("oq 9 spad_ready", 32'(bus.o_spad_ready), 1);
        fill_seq(11'h010);
        ag_send();
        expect_seq(8'hA0, 4); spad_send(8'd2, make_word(8'hA0));
        check("oq 13 spad_ready", 32'(bus.o_spad_ready), 0);
        expect_seq(8'hA4, 4);
        bus.i_spad_addr  = 8'd2;
        bus.i_spad_data  = make_word(8'hA0);
        bus.i_spad_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stalled spad_ready", 32'(bus.o_spad_ready), 0);
        check("stalled aq_empty", 32'(bus.o_aq_empty), 0);
        bus.i_ready = 1'b1;
        spad_send(8'd2, make_word(8'hA0));
        expect_seq(8'hB0, 1); spad_send(8'd3, make_word(8'hB0));
        wait_drain();
        check("backpressure elem_count", 32'(bus.o_elem_count), 27);

        // Address write, spad accept and output pop in one cycle, pointers wrapping
        fill_seq(11'h020);
        ag_send();
        expect_seq(8'hC0, 4); spad_send(8'd4, make_word(8'hC0));
        fill_seq(11'h029);
        load_av();
        expect_seq(8'hC4, 4);
        bus.i_ag_valid   = 1'b1;
        bus.i_spad_addr  = 8'd4;
        bus.i_spad_data  = make_word(8'hC0);
        bus.i_spad_valid = 1'b1;
        check("simul ag_ready", 32'(bus.o_ag_ready), 1);
        check("simul spad_ready", 32'(bus.o_spad_ready), 1);
        check("simul o_valid", 32'(bus.o_valid), 1);
        @(posedge clk); #1;
        bus.i_ag_valid   = 1'b0;
        bus.i_spad_valid = 1'b0;
        expect_seq(8'hD0, 4); spad_send(8'd5, make_word(8'hD0));
        expect_seq(8'hD4, 4); spad_send(8'd5, make_word(8'hD0));
        expect_seq(8'hE0, 2); spad_send(8'd6, make_word(8'hE0));
        wait_drain();
        check("simul aq_empty", 32'(bus.o_aq_empty), 1);
        check("simul elem_count", 32'(bus.o_elem_count), 45);

`ifdef STREAM_ROW_ROUTER_PAD_EN
        // Pad entries emit zeros without a scratchpad word
        for (int i = 0; i < ADDR_LENGTH; i++) av[i] = ADDR_WIDTH'(i - 2);
        av[0] = '1;
        av[1] = '1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        ag_send();
        repeat (4) @(posedge clk);
        #1;
        check("pad queue drained", 32'(exp_q.size()), 0);
        check("pad waits aq_empty", 32'(bus.o_aq_empty), 0);
        expect_seq(8'hF0, 4); spad_send(8'd0, make_word(8'hF0));
        expect_seq(8'hF4, 3); spad_send(8'd0, make_word(8'hF0));
        wait_drain();
        check("pad elem_count", 32'(bus.o_elem_count), 54);
        check("pad aq_empty", 32'(bus.o_aq_empty), 1);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_row_router.md
# stream_row_router

Next-generation input row router for the CNN accelerator. It buffers element addresses from the address generator in an in-order address queue. It matches up to PEEK_W queued addresses per cycle against each scratchpad word streamed past it, and drains the matched elements into an output queue with a valid/ready interface toward the PE row. Compared with the previous router it adds:
- a parametrised multi-pop width
- backpressure on both the address and scratchpad sides
- an emitted-element counter
- optional zero-padding entries

## Interface
- DATA_WIDTH, 8, element width
- SPAD_N, 8, elements per scratchpad word
- WORD_ADDR_WIDTH, 8, scratchpad word address width
- ADDR_WIDTH, WORD_ADDR_WIDTH+$clog2(SPAD_N), element address {word, lane} (derived)
- ADDR_LENGTH, 9, addresses written per generator transfer
- AQ_DEPTH, 16, address queue depth (power of two, ≥ ADDR_LENGTH)
- OQ_DEPTH, 16, output queue depth (power of two, ≥ PEEK_W)
- PEEK_W, 4, head entries compared per cycle (1..SPAD_N)
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  reset, synchronous, active-high
- i_clear  in  1  synchronous flush, same effect as reset
- i_ag_addr  in  ADDR_LENGTH×ADDR_WIDTH  address vector; index 0 is oldest
- i_ag_valid  in  1  address vector valid
- o_ag_ready  out  1  address queue free ≥ ADDR_LENGTH
- i_spad_data  in  SPAD_N×DATA_WIDTH  scratchpad word; lane 0 in LSBs
- i_spad_addr  in  WORD_ADDR_WIDTH  word address
- i_spad_valid  in  1  word valid
- o_spad_ready  out  1  output queue free ≥ PEEK_W
- o_data  out  DATA_WIDTH  output queue head
- o_valid  out  1  output queue not empty
- i_ready  in  1  consumer accepts head
- o_aq_empty  out  1  address queue empty
- o_elem_count  out  16  elements emitted since reset/clear; wraps

## Operation
- The address queue is a circular FIFO with a registered count.
  - Write: i_ag_valid & o_ag_ready pushes all ADDR_LENGTH entries at once, in index order.
- Accept: i_spad_valid & o_spad_ready.
  - An accepted word is always consumed, whether or not any entry matches it.
  - A stalled word is held by the source.
- Head entry k (k < PEEK_W, k < count) qualifies when:
  - the cycle is an accept, and
  - entry k's address bits [ADDR_WIDTH-1:$clog2(SPAD_N)] equal i_spad_addr.
- Run length n is the number of leading qualifying entries; the first non-qualifying entry stops the run.
  - n entries are popped and n elements are pushed to the output queue in order.
  - Element k is lane addr[$clog2(SPAD_N)-1:0] of i_spad_data.
- Output queue:
  - FIFO with registered count.
  - Pop on o_valid & i_ready.
  - Push and pop in the same cycle are legal.
  - The count updates by n − pop.
- o_elem_count increments by 1 on each output pop.
- The ready outputs are computed from registered counts only, so same-cycle pops give no credit.
- i_rst has priority over i_clear. i_clear in the same cycle as any write or pop flushes everything, and that write is dropped.

## Timing
- Reset/clear values:
  - o_valid=0, o_data=0, o_aq_empty=1
  - o_ag_ready=1, o_spad_ready=1
  - o_elem_count=0
  - all pointers and counts 0
- Address write at edge t → entries visible for matching from cycle t+1.
- Spad accept at edge t → first pushed element on o_data, with o_valid=1, from cycle t+1.
- Maximum throughput:
  - PEEK_W elements in per cycle
  - 1 element out per cycle
- Pointer wrap-around is modulo depth.
- An empty address queue gives n=0, and an accept still consumes the word.

## Configuration
- STREAM_ROW_ROUTER_PAD_EN defined:
  - An address of all ones is a pad entry.
  - Pad entries qualify unconditionally, with or without an accept, but only while o_spad_ready=1.
  - A pad entry pushes the value 0.
  - Pad entries may mix with matching entries in one run.
- Not defined: all-ones is an ordinary address.

## Test plan
- Reset/clear: assert i_rst, then drive i_clear mid-stream with a full address queue → all outputs return to the reset values listed above; the next data matches only newly written addresses.
- Contiguous multi-pop, PEEK_W=4:
  - stimulus: addresses 0x00..0x08; words addr 0 (bytes 0x10..0x17), addr 0, addr 1 (lane 0 = 0x20)
  - response: o_data sequence 0x10..0x17, 0x20; pops per accept 4, 4, 1; o_elem_count=9
- Sparse match:
  - stimulus: addresses {0x05, 0x09, ...}; word 0
  - response: emits lane 5 only, n=1; word 1 then emits its lane 1
- Backpressure, OQ_DEPTH=16:
  - stimulus: hold i_ready=0 and stream hits
  - response: o_spad_ready drops once 13 elements are queued; release i_ready → no loss or duplication; o_ag_ready drops when address queue free < 9
- Pad, macro on:
  - stimulus: addresses {all-ones, all-ones, 0x00, ...}; no i_spad_valid
  - response: two 0x00 elements pushed in one cycle; then waits; word 0 supplies lane 0
- Simultaneous events: address write, spad accept and output pop in the same cycle with wrap-around → counts and ordering are exact.
